// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer for one R-type ALU instruction: fetches operands,
// drives the ALU, then performs a flag-conditional register writeback.
module alu_op_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [15:0]  in_instr,
  output logic         in_ready,
  output logic [2:0]   rf_ra_addr,
  output logic [2:0]   rf_rb_addr,
  input  logic [W-1:0] rf_ra_data,
  input  logic [W-1:0] rf_rb_data,
  output logic         rf_we,
  output logic [2:0]   rf_wr_addr,
  output logic [W-1:0] rf_wr_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_zero,
  input  logic         alu_carry,
  output logic         done,
  output logic         skipped,
  output logic         err,
  output logic         z_flag,
  output logic         c_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_NAND = 4'b0001;
  localparam logic [3:0] CTRL_SUB  = 4'b0010;

  state_t         state_q, state_d;
  logic [3:0]     opc_q, opc_d;
  logic [2:0]     ra_q, ra_d;
  logic [2:0]     rb_q, rb_d;
  logic [2:0]     rc_q, rc_d;
  logic [1:0]     cz_q, cz_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [3:0]     ctrl_q, ctrl_d;
  logic           upd_c_q, upd_c_d;
  logic           skip_q, skip_d;
  logic           err_q, err_d;
  logic [W-1:0]   res_q, res_d;
  logic           zero_q, zero_d;
  logic           carry_q, carry_d;
  logic           z_q, z_d;
  logic           c_q, c_d;

  logic           dec_legal;
  logic           dec_cond_ok;
  logic           dec_upd_c;
  logic [3:0]     dec_ctrl;
  logic           unused_bits;

  // Instruction bit 2 carries no meaning for these R-type forms.
  assign unused_bits = in_instr[2];

  // Decode of the latched instruction; conditions use the flags as they stand now.
  always_comb begin
    dec_legal   = 1'b0;
    dec_cond_ok = 1'b0;
    dec_upd_c   = 1'b0;
    dec_ctrl    = CTRL_ADD;
    case (opc_q)
      4'b0000: begin
        dec_ctrl  = CTRL_ADD;
        dec_upd_c = 1'b1;
        case (cz_q)
          2'b00: begin dec_legal = 1'b1; dec_cond_ok = 1'b1; end
          2'b10: begin dec_legal = 1'b1; dec_cond_ok = c_q;  end
          2'b01: begin dec_legal = 1'b1; dec_cond_ok = z_q;  end
          default: ;
        endcase
      end
      4'b0010: begin
        dec_ctrl = CTRL_NAND;
        case (cz_q)
          2'b00: begin dec_legal = 1'b1; dec_cond_ok = 1'b1; end
          2'b10: begin dec_legal = 1'b1; dec_cond_ok = c_q;  end
          2'b01: begin dec_legal = 1'b1; dec_cond_ok = z_q;  end
          default: ;
        endcase
      end
      4'b0001: begin
        dec_ctrl = CTRL_SUB;
        if (cz_q == 2'b00) begin
          dec_legal   = 1'b1;
          dec_cond_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    cz_d    = cz_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    ctrl_d  = ctrl_q;
    upd_c_d = upd_c_q;
    skip_d  = skip_q;
    err_d   = err_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          opc_d   = in_instr[15:12];
          ra_d    = in_instr[11:9];
          rb_d    = in_instr[8:6];
          rc_d    = in_instr[5:3];
          cz_d    = in_instr[1:0];
          state_d = S_READ;
        end
      end
      S_READ: begin
        op_a_d  = rf_ra_data;
        op_b_d  = rf_rb_data;
        ctrl_d  = dec_ctrl;
        upd_c_d = dec_upd_c;
        err_d   = ~dec_legal;
        skip_d  = dec_legal & ~dec_cond_ok;
        state_d = (dec_legal && dec_cond_ok) ? S_EXEC : S_WB;
      end
      S_EXEC: begin
        res_d   = alu_out;
        zero_d  = alu_zero;
        carry_d = alu_carry;
        state_d = S_WB;
      end
      S_WB: begin
        if (!skip_q && !err_q) begin
          z_d = zero_q;
          if (upd_c_q) begin
            c_d = carry_q;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cz_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ctrl_q  <= '0;
      upd_c_q <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cz_q    <= cz_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      ctrl_q  <= ctrl_d;
      upd_c_q <= upd_c_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  // Outputs are decoded from state so every bus idles at zero outside its phase.
  always_comb begin
    in_ready   = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    rf_we      = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctrl   = '0;
    done       = 1'b0;
    skipped    = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_READ: begin
        rf_ra_addr = ra_q;
        rf_rb_addr = rb_q;
      end
      S_EXEC: begin
        alu_a    = op_a_q;
        alu_b    = op_b_q;
        alu_ctrl = ctrl_q;
      end
      S_WB: begin
        done    = 1'b1;
        skipped = skip_q;
        err     = err_q;
        if (!skip_q && !err_q) begin
          rf_we      = 1'b1;
          rf_wr_addr = rc_q;
          rf_wr_data = res_q;
        end
      end
      default: ;
    endcase
  end

  assign z_flag = z_q;
  assign c_flag = c_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural register file and ALU.
module tb_alu_op_sequencer;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [15:0]  in_instr;
  logic         in_ready;
  logic [2:0]   rf_ra_addr, rf_rb_addr;
  logic [W-1:0] rf_ra_data, rf_rb_data;
  logic         rf_we;
  logic [2:0]   rf_wr_addr;
  logic [W-1:0] rf_wr_data;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_zero, alu_carry;
  logic         done, skipped, err, z_flag, c_flag;

  logic [W-1:0] rf [8];
  int checks = 0;
  int failures = 0;

  alu_op_sequencer #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_ra_data(rf_ra_data),
    .rf_rb_data(rf_rb_data), .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_zero(alu_zero), .alu_carry(alu_carry), .done(done), .skipped(skipped),
    .err(err), .z_flag(z_flag), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  // Reference ALU: SUB reports borrow on carry, NAND clears carry.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    case (alu_ctrl)
      4'b0000: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0001: alu_out = ~(alu_a & alu_b);
      4'b0010: begin
        alu_out   = alu_a - alu_b;
        alu_carry = (alu_a < alu_b);
      end
      default: ;
    endcase
    alu_zero = (alu_out == '0);
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic        exp_exec;
    logic        exp_skip;
    logic        exp_err;
    logic [15:0] exp_data;
    logic [3:0]  exp_ctrl;
    logic        exp_z;
    logic        exp_c;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          done_cyc;
    logic        we_seen, sk, er;
    logic [2:0]  wa, ra_seen, rb_seen;
    logic [15:0] wd;
    logic [3:0]  ctrl2;
    done_cyc = 0; we_seen = 0; sk = 0; er = 0; wa = 0; wd = 0; ctrl2 = 0;
    ra_seen = 0; rb_seen = 0;
    @(negedge clk);
    rf[v.instr[11:9]] = v.a_val;
    rf[v.instr[8:6]]  = v.b_val;
    in_instr = v.instr;
    in_valid = 1'b1;
    check("ready_before", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_instr = 16'hA5A5;
    for (int cyc = 1; cyc <= 6 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin ra_seen = rf_ra_addr; rb_seen = rf_rb_addr; end
      if (cyc == 2) ctrl2 = alu_ctrl;
      if (rf_we) begin
        we_seen = 1'b1;
        wa = rf_wr_addr;
        wd = rf_wr_data;
        rf[rf_wr_addr] = rf_wr_data;
      end
      if (done) begin
        done_cyc = cyc;
        sk = skipped;
        er = err;
      end else begin
        check("qual_idle", {30'd0, skipped, err}, 32'd0);
      end
    end
    check("ra_addr", {29'd0, ra_seen}, {29'd0, v.instr[11:9]});
    check("rb_addr", {29'd0, rb_seen}, {29'd0, v.instr[8:6]});
    check("done_cycle", done_cyc, v.exp_exec ? 32'd3 : 32'd2);
    check("skipped", {31'd0, sk}, {31'd0, v.exp_skip});
    check("err", {31'd0, er}, {31'd0, v.exp_err});
    check("we_seen", {31'd0, we_seen}, {31'd0, v.exp_exec});
    if (v.exp_exec) begin
      check("wr_addr", {29'd0, wa}, {29'd0, v.instr[5:3]});
      check("wr_data", {16'd0, wd}, {16'd0, v.exp_data});
    end
    check("alu_ctrl_c2", {28'd0, ctrl2}, {28'd0, v.exp_ctrl});
    @(posedge clk);
    #1;
    check("z_flag", {31'd0, z_flag}, {31'd0, v.exp_z});
    check("c_flag", {31'd0, c_flag}, {31'd0, v.exp_c});
    check("ready_after", {31'd0, in_ready}, 32'd1);
    $display("vec %0d instr=%h done_cyc=%0d skip=%0b err=%0b we=%0b data=%h z=%0b c=%0b",
             idx, v.instr, done_cyc, sk, er, we_seen, wd, z_flag, c_flag);
  endtask

  initial begin
    // instr, a, b, exec, skip, err, data, ctrl, z, c
    vecs[0]  = '{16'h029A, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0}; // ADC, C=0
    vecs[1]  = '{16'h0298, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1}; // ADD carry
    vecs[2]  = '{16'h029A, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFE, 4'h0, 1'b0, 1'b1}; // ADC, C=1
    vecs[3]  = '{16'h1970, 16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h2, 1'b1, 1'b1}; // SUB
    vecs[4]  = '{16'h2299, 16'hF0F0, 16'h0FF0, 1'b1, 1'b0, 1'b0, 16'hFF0F, 4'h1, 1'b0, 1'b1}; // NDZ, Z=1
    vecs[5]  = '{16'h2299, 16'hF0F0, 16'h0FF0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1}; // NDZ, Z=0
    vecs[6]  = '{16'hF000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b1}; // bad opcode
    vecs[7]  = '{16'h1972, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b1}; // SUB, CZ!=0
    vecs[8]  = '{16'h0299, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b1}; // ADZ, Z=0
    vecs[9]  = '{16'h229A, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h1, 1'b1, 1'b1}; // NDC, C=1
    vecs[10] = '{16'h0299, 16'h0001, 16'h0002, 1'b1, 1'b0, 1'b0, 16'h0003, 4'h0, 1'b0, 1'b0}; // ADZ, Z=1
    vecs[11] = '{16'h229A, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0}; // NDC, C=0
    vecs[12] = '{16'h029B, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 4'h0, 1'b0, 1'b0}; // ADD, CZ=11
    vecs[13] = '{16'h0298, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 4'h0, 1'b1, 1'b1}; // set Z,C
    vecs[14] = '{16'h1970, 16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 16'hFFFE, 4'h2, 1'b0, 1'b0}; // SUB borrow

    for (int i = 0; i < 8; i++) rf[i] = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ctrl", {23'd0, rf_we, done, skipped, err, z_flag, c_flag, rf_ra_addr},
          32'd0);
    check("rst_data", {rf_wr_data, alu_a}, 32'd0);
    check("rst_alu", {9'd0, rf_wr_addr, rf_rb_addr, alu_ctrl, alu_b}, 32'd0);
    $display("reset ready=%0b we=%0b done=%0b z=%0b c=%0b", in_ready, rf_we, done, z_flag, c_flag);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Reset asserted during EXEC of an ADD must abort it and clear the flags.
    @(negedge clk);
    rf[1] = 16'hFFFF;
    rf[2] = 16'h0001;
    in_instr = 16'h0298;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("exec_ctrl_before_rst", {28'd0, alu_ctrl, 16'd0} | {16'd0, alu_a}, 32'h0000_FFFF);
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec_we", {31'd0, rf_we}, 32'd0);
    check("rst_exec_done", {31'd0, done}, 32'd0);
    check("rst_exec_flags", {30'd0, z_flag, c_flag}, 32'd0);
    check("rst_exec_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_quiet", {30'd0, rf_we, done}, 32'd0);
    end
    $display("reset-in-exec we=%0b done=%0b z=%0b c=%0b ready=%0b", rf_we, done, z_flag, c_flag, in_ready);

    run_vec(14, vecs[14]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
